// File: rtl/intercept_round_ctrl.sv
// Intercept game round controller: turns the divider's slow square wave into game ticks,
// sweeps a target across NPOS positions, scores intercepts and times out the round.

package intercept_round_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HIT  = 2'b10,
        OVER = 2'b11
    } state_t;
endpackage

module intercept_round_ctrl
    import intercept_round_pkg::*;
#(
    parameter int NPOS        = 8,
    parameter int POS_W       = 3,
    parameter int ROUND_TICKS = 50,
    parameter int HIT_TICKS   = 2,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               slow_clk,
    input  logic               start,
    input  logic               fire,
    input  logic [POS_W-1:0]   aim,
    output logic [POS_W-1:0]   target_pos,
    output logic [7:0]         time_left,
    output logic [SCORE_W-1:0] score,
    output logic               hit,
    output logic [1:0]         state,
    output logic               game_over
);

    localparam int                 HOLD_W     = $clog2(HIT_TICKS + 1);
    localparam logic [POS_W-1:0]   POS_TOP    = POS_W'(NPOS - 1);
    localparam logic [POS_W-1:0]   POS_BELOW  = POS_W'(NPOS - 2);
    localparam logic [POS_W-1:0]   POS_ONE    = POS_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

    state_t            state_q;
    logic              slow_d;
    logic              dir_up;
    logic [HOLD_W-1:0] hold;

    logic tick;
    logic intercept;

    // slow_clk is already synchronous to clk, so a single delay stage is enough.
    assign tick      = slow_clk & ~slow_d;
    assign intercept = fire && (aim == target_pos);
    assign state     = state_q;

    // NOTE: every register here uses <= so all branches see the pre-edge values; a later
    // assignment in the same cycle (the timeout below) intentionally overrides an earlier one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            slow_d     <= 1'b0;
            dir_up     <= 1'b1;
            hold       <= '0;
            target_pos <= '0;
            time_left  <= '0;
            score      <= '0;
            hit        <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            slow_d <= slow_clk;
            hit    <= 1'b0;

            unique case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        state_q    <= RUN;
                        game_over  <= 1'b0;
                        time_left  <= 8'(ROUND_TICKS);
                        score      <= '0;
                        target_pos <= '0;
                        dir_up     <= 1'b1;
                        hold       <= '0;
                    end
                end

                RUN: begin
                    if (intercept) begin
                        if (score != '1) score <= score + SCORE_ONE;
                        hit     <= 1'b1;
                        state_q <= HIT;
                        hold    <= HOLD_W'(HIT_TICKS);
                    end else if (tick) begin
                        // Ends reflect immediately, so the target never dwells on 0 or NPOS-1.
                        if (dir_up) begin
                            if (target_pos == POS_TOP) begin
                                target_pos <= POS_BELOW;
                                dir_up     <= 1'b0;
                            end else begin
                                target_pos <= target_pos + POS_ONE;
                            end
                        end else begin
                            if (target_pos == '0) begin
                                target_pos <= POS_ONE;
                                dir_up     <= 1'b1;
                            end else begin
                                target_pos <= target_pos - POS_ONE;
                            end
                        end
                    end
                end

                HIT: begin
                    if (tick) begin
                        hold <= hold - HOLD_ONE;
                        if (hold <= HOLD_ONE) state_q <= RUN;
                    end
                end

                default: state_q <= IDLE;
            endcase

            // The round clock runs in RUN and HIT and wins over any transition above.
            if (tick && (state_q == RUN || state_q == HIT)) begin
                if (time_left <= 8'd1) begin
                    time_left <= '0;
                    state_q   <= OVER;
                    game_over <= 1'b1;
                end else begin
                    time_left <= time_left - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_intercept_round_ctrl.sv
// Bench for intercept_round_ctrl: a table of per-cycle stimulus and expected registered
// outputs, replayed through a scoreboard queue and compared one cycle after each drive.

module tb_intercept_round_ctrl;

    localparam int NPOS        = 4;
    localparam int POS_W       = 2;
    localparam int ROUND_TICKS = 6;
    localparam int HIT_TICKS   = 2;
    localparam int SCORE_W     = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               slow_clk;
    logic               start;
    logic               fire;
    logic [POS_W-1:0]   aim;
    logic [POS_W-1:0]   target_pos;
    logic [7:0]         time_left;
    logic [SCORE_W-1:0] score;
    logic               hit;
    logic [1:0]         state;
    logic               game_over;

    intercept_round_ctrl #(
        .NPOS(NPOS), .POS_W(POS_W), .ROUND_TICKS(ROUND_TICKS),
        .HIT_TICKS(HIT_TICKS), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .start(start), .fire(fire),
        .aim(aim), .target_pos(target_pos), .time_left(time_left), .score(score),
        .hit(hit), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             slow;
        logic             st;
        logic             fr;
        logic [POS_W-1:0] aim;
        logic [POS_W-1:0] tp;
        logic [7:0]       tl;
        logic [7:0]       sc;
        logic             ht;
        logic [1:0]       sm;
        string            tag;
    } vec_t;

    typedef struct {
        logic [POS_W-1:0] tp;
        logic [7:0]       tl;
        logic [7:0]       sc;
        logic             ht;
        logic [1:0]       sm;
        string            tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic void add(input string tag, input logic r, input logic s, input logic st,
                                input logic f, input int a, input int tp, input int tl,
                                input int sc, input logic h, input int sm);
        vec_t v;
        v.tag = tag; v.rst_n = r; v.slow = s; v.st = st; v.fr = f; v.aim = POS_W'(a);
        v.tp = POS_W'(tp); v.tl = 8'(tl); v.sc = 8'(sc); v.ht = h; v.sm = 2'(sm);
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        reset    = v.rst_n;
        slow_clk = v.slow;
        start    = v.st;
        fire     = v.fr;
        aim      = v.aim;
        e.tp = v.tp; e.tl = v.tl; e.sc = v.sc; e.ht = v.ht; e.sm = v.sm; e.tag = v.tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({v.tag, ".scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".target_pos"}, 32'(target_pos), 32'(e.tp));
            check({e.tag, ".time_left"},  32'(time_left),  32'(e.tl));
            check({e.tag, ".score"},      32'(score),      32'(e.sc));
            check({e.tag, ".hit"},        32'(hit),        32'(e.ht));
            check({e.tag, ".state"},      32'(state),      32'(e.sm));
            check({e.tag, ".game_over"},  32'(game_over),  32'(e.sm == 2'b11));
        end
    endtask

    initial begin
        //   tag          rst slow st fire aim   tp tl sc hit st
        for (int i = 0; i < 3; i++)
            add("reset",     0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add("idle",          1, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add("idle_fire",     1, 0, 0, 1, 0,      0, 0, 0, 0, 0);
        add("idle_tick",     1, 1, 0, 0, 0,      0, 0, 0, 0, 0);
        add("start",         1, 0, 1, 0, 0,      0, 6, 0, 0, 1);
        // Full sweep with no fire: 1,2,3,2,1,0 then OVER.
        add("sweep_t1",      1, 1, 0, 0, 0,      1, 5, 0, 0, 1);
        add("sweep_l1",      1, 0, 0, 0, 0,      1, 5, 0, 0, 1);
        add("sweep_t2",      1, 1, 0, 0, 0,      2, 4, 0, 0, 1);
        add("sweep_l2",      1, 0, 0, 0, 0,      2, 4, 0, 0, 1);
        add("sweep_t3",      1, 1, 0, 0, 0,      3, 3, 0, 0, 1);
        add("sweep_l3",      1, 0, 0, 0, 0,      3, 3, 0, 0, 1);
        add("sweep_t4",      1, 1, 0, 0, 0,      2, 2, 0, 0, 1);
        add("sweep_l4",      1, 0, 0, 0, 0,      2, 2, 0, 0, 1);
        add("sweep_t5",      1, 1, 0, 0, 0,      1, 1, 0, 0, 1);
        add("sweep_l5",      1, 0, 0, 0, 0,      1, 1, 0, 0, 1);
        add("sweep_t6",      1, 1, 0, 0, 0,      0, 0, 0, 0, 3);
        add("over_hold",     1, 0, 0, 0, 0,      0, 0, 0, 0, 3);
        add("over_tick",     1, 1, 0, 1, 0,      0, 0, 0, 0, 3);
        add("over_start",    1, 0, 1, 0, 0,      0, 6, 0, 0, 1);
        // Hit at target 2, freeze for two ticks, then resume upward.
        add("hit_t1",        1, 1, 0, 0, 0,      1, 5, 0, 0, 1);
        add("hit_l1",        1, 0, 0, 0, 0,      1, 5, 0, 0, 1);
        add("hit_t2",        1, 1, 0, 0, 0,      2, 4, 0, 0, 1);
        add("hit_l2",        1, 0, 0, 0, 0,      2, 4, 0, 0, 1);
        add("run_start",     1, 0, 1, 0, 0,      2, 4, 0, 0, 1);
        add("miss",          1, 0, 0, 1, 1,      2, 4, 0, 0, 1);
        add("hit",           1, 0, 0, 1, 2,      2, 4, 1, 1, 2);
        add("hit_after",     1, 0, 0, 0, 2,      2, 4, 1, 0, 2);
        add("hit_fire_ign",  1, 0, 0, 1, 2,      2, 4, 1, 0, 2);
        add("frz_t1",        1, 1, 0, 0, 0,      2, 3, 1, 0, 2);
        add("frz_l1",        1, 0, 0, 0, 0,      2, 3, 1, 0, 2);
        add("frz_t2",        1, 1, 0, 0, 0,      2, 2, 1, 0, 1);
        add("frz_l2",        1, 0, 0, 0, 0,      2, 2, 1, 0, 1);
        add("resume",        1, 1, 0, 0, 0,      3, 1, 1, 0, 1);
        add("resume_l",      1, 0, 0, 0, 0,      3, 1, 1, 0, 1);
        // Hit coincident with the final tick: scores, pulses, ends round, target stays.
        add("final_hit",     1, 1, 0, 1, 3,      3, 0, 2, 1, 3);
        add("final_after",   1, 0, 0, 0, 3,      3, 0, 2, 0, 3);
        // Held slow_clk gives exactly one tick.
        add("restart",       1, 0, 1, 0, 0,      0, 6, 0, 0, 1);
        add("held_1",        1, 1, 0, 0, 0,      1, 5, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            add("held_n",    1, 1, 0, 0, 0,      1, 5, 0, 0, 1);
        add("held_low",      1, 0, 0, 0, 0,      1, 5, 0, 0, 1);
        // Build score to 3, then reset mid-round.
        add("s1",            1, 0, 0, 1, 1,      1, 5, 1, 1, 2);
        add("s1_t1",         1, 1, 0, 0, 0,      1, 4, 1, 0, 2);
        add("s1_l1",         1, 0, 0, 0, 0,      1, 4, 1, 0, 2);
        add("s1_t2",         1, 1, 0, 0, 0,      1, 3, 1, 0, 1);
        add("s2",            1, 0, 0, 1, 1,      1, 3, 2, 1, 2);
        add("s2_t1",         1, 1, 0, 0, 0,      1, 2, 2, 0, 2);
        add("s2_l1",         1, 0, 0, 0, 0,      1, 2, 2, 0, 2);
        add("s2_t2",         1, 1, 0, 0, 0,      1, 1, 2, 0, 1);
        add("s2_l2",         1, 0, 0, 0, 0,      1, 1, 2, 0, 1);
        add("s3",            1, 0, 0, 1, 1,      1, 1, 3, 1, 2);
        add("s3_after",      1, 0, 0, 0, 1,      1, 1, 3, 0, 2);
        add("mid_reset",     0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add("post_reset",    1, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        add("post_tick",     1, 1, 0, 1, 0,      0, 0, 0, 0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
